// File: rtl/desserializador_pkg.sv
// rtl/desserializador_pkg.sv - shared types and defaults for the word deserializer (optional feature: DESSER_PARIDADE_EN)
package desserializador_pkg;

  localparam int LARGURA_PADRAO = 16;

`ifdef DESSER_PARIDADE_EN
  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    RECEBE   = 2'd1,
    PARIDADE = 2'd2,
    ENTREGA  = 2'd3
  } estado_t;
`else
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    RECEBE  = 2'd1,
    ENTREGA = 2'd3
  } estado_t;
`endif

endpackage

// File: rtl/desserializador_palavra_if.sv
// rtl/desserializador_palavra_if.sv - serial input / word output bundle (erro_paridade only with DESSER_PARIDADE_EN)
interface desserializador_palavra_if #(
  parameter int LARGURA = 16
);

  logic               inicio;
  logic               bit_in;
  logic               bit_valido;
  logic [LARGURA-1:0] palavra;
  logic               palavra_valida;
  logic               ocupado;
`ifdef DESSER_PARIDADE_EN
  logic               erro_paridade;
`endif

  modport master (
    output inicio,
    output bit_in,
    output bit_valido,
    input  palavra,
    input  palavra_valida,
`ifdef DESSER_PARIDADE_EN
    input  erro_paridade,
`endif
    input  ocupado
  );

  modport slave (
    input  inicio,
    input  bit_in,
    input  bit_valido,
    output palavra,
    output palavra_valida,
`ifdef DESSER_PARIDADE_EN
    output erro_paridade,
`endif
    output ocupado
  );

endinterface

// File: rtl/desserializador_palavra_contador_bits.sv
// rtl/desserializador_palavra_contador_bits.sv - saturating bit counter with clear, enable and last-bit flag
module contador_bits #(
  parameter int LIMITE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_limpa,
  input  logic i_habilita,
  output logic o_terminal
);

  localparam int W = $clog2(LIMITE + 1);
  localparam logic [W-1:0] C_LIMITE = W'(LIMITE);
  localparam logic [W-1:0] C_ULTIMO = W'(LIMITE - 1);

  logic [W-1:0] r_contagem;

  // Count accepted bits; clear has priority and the count never passes LIMITE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_contagem <= '0;
    end else if (i_limpa) begin
      r_contagem <= '0;
    end else if (i_habilita && (r_contagem != C_LIMITE)) begin
      r_contagem <= r_contagem + 1'b1;
    end
  end

  // High while the next accepted bit is the final bit of the word
  assign o_terminal = (r_contagem == C_ULTIMO);

endmodule

// File: rtl/desserializador_palavra.sv
// rtl/desserializador_palavra.sv - MSB-first serial to parallel word deserializer (optional parity: DESSER_PARIDADE_EN)
module desserializador_palavra
  import desserializador_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input logic                       clk,
  input logic                       rst,
  desserializador_palavra_if.slave  bus
);

  estado_t            r_estado;
  logic [LARGURA-1:0] r_desloc;
  logic [LARGURA-1:0] r_palavra;
  logic               r_valida;
  logic               r_ocupado;
  logic               w_aceita;
  logic               w_ultimo;
  logic [LARGURA-1:0] w_proximo;
`ifdef DESSER_PARIDADE_EN
  logic               r_erro;
`endif

  // A bit is taken only in RECEBE; a restart on the same cycle drops it
  assign w_aceita  = (r_estado == RECEBE) && bus.bit_valido && !bus.inicio;
  assign w_proximo = LARGURA'({r_desloc, bus.bit_in});

  contador_bits #(
    .LIMITE (LARGURA)
  ) u_contador (
    .clk        (clk),
    .rst        (rst),
    .i_limpa    (bus.inicio),
    .i_habilita (w_aceita),
    .o_terminal (w_ultimo)
  );

  // Frame FSM with registered outputs; ocupado follows the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado  <= OCIOSO;
      r_desloc  <= '0;
      r_palavra <= '0;
      r_valida  <= 1'b0;
      r_ocupado <= 1'b0;
`ifdef DESSER_PARIDADE_EN
      r_erro    <= 1'b0;
`endif
    end else begin
      r_valida <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (bus.inicio) begin
            r_estado  <= RECEBE;
            r_desloc  <= '0;
            r_ocupado <= 1'b1;
          end
        end
        RECEBE: begin
          if (bus.inicio) begin
            r_desloc <= '0;
          end else if (bus.bit_valido) begin
            r_desloc <= w_proximo;
            if (w_ultimo) begin
`ifdef DESSER_PARIDADE_EN
              r_estado  <= PARIDADE;
`else
              r_estado  <= ENTREGA;
              r_palavra <= w_proximo;
              r_valida  <= 1'b1;
              r_ocupado <= 1'b0;
`endif
            end
          end
        end
`ifdef DESSER_PARIDADE_EN
        PARIDADE: begin
          if (bus.inicio) begin
            r_estado <= RECEBE;
            r_desloc <= '0;
          end else if (bus.bit_valido) begin
            r_estado  <= ENTREGA;
            r_palavra <= r_desloc;
            r_erro    <= (^r_desloc) ^ bus.bit_in;
            r_valida  <= 1'b1;
            r_ocupado <= 1'b0;
          end
        end
`endif
        ENTREGA: begin
          if (bus.inicio) begin
            r_estado  <= RECEBE;
            r_desloc  <= '0;
            r_ocupado <= 1'b1;
          end else begin
            r_estado <= OCIOSO;
          end
        end
        default: begin
          r_estado  <= OCIOSO;
          r_ocupado <= 1'b0;
        end
      endcase
    end
  end

  assign bus.palavra        = r_palavra;
  assign bus.palavra_valida = r_valida;
  assign bus.ocupado        = r_ocupado;
`ifdef DESSER_PARIDADE_EN
  assign bus.erro_paridade  = r_erro;
`endif

endmodule

// File: tb/tb_desserializador_palavra.sv
// tb/tb_desserializador_palavra.sv - directed self-checking bench for desserializador_palavra (DESSER_PARIDADE_EN aware)
module tb_desserializador_palavra;

`ifdef DESSER_PARIDADE_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_erros;
  int   n_pulsos;
  int   falhas_gap;
  int   p0;

  desserializador_palavra_if #(.LARGURA(16)) bus ();

  desserializador_palavra #(.LARGURA(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count delivery pulses, sampled after the edge has settled
  always @(posedge clk) begin
    #2;
    if (bus.palavra_valida === 1'b1) n_pulsos++;
  end

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_erros++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
    end
  endtask

  function automatic logic [16:0] quadro(input logic [15:0] w);
`ifdef DESSER_PARIDADE_EN
    return {w, ^w};
`else
    return {1'b0, w};
`endif
  endfunction

  task automatic iniciar();
    @(negedge clk);
    bus.inicio     = 1'b1;
    bus.bit_in     = 1'b1;
    bus.bit_valido = 1'b1;
  endtask

  task automatic bits(input logic [16:0] w, input int n, input bit gap);
    for (int i = NB - 1; i >= NB - n; i--) begin
      @(negedge clk);
      bus.inicio     = 1'b0;
      bus.bit_in     = w[i];
      bus.bit_valido = 1'b1;
      if (gap && i != NB - n) begin
        @(negedge clk);
        bus.bit_valido = 1'b0;
        bus.bit_in     = ~w[i];
        if (bus.ocupado !== 1'b1) falhas_gap++;
      end
    end
  endtask

  initial begin
    n_checks = 0; n_erros = 0; n_pulsos = 0; falhas_gap = 0;
    rst = 1'b1;
    bus.inicio = 1'b0; bus.bit_in = 1'b0; bus.bit_valido = 1'b0;
    repeat (3) @(negedge clk);
    verifica("rst_palavra", 32'(bus.palavra), 32'h0);
    verifica("rst_valida", 32'(bus.palavra_valida), 32'h0);
    verifica("rst_ocupado", 32'(bus.ocupado), 32'h0);
    rst = 1'b0;

    // Plain frame 0x4A44
    p0 = n_pulsos;
    iniciar();
    bits(quadro(16'h4A44), NB, 1'b0);
    @(negedge clk);
    bus.bit_valido = 1'b0;
    verifica("f1_valida", 32'(bus.palavra_valida), 32'h1);
    verifica("f1_palavra", 32'(bus.palavra), 32'h4A44);
    verifica("f1_ocupado", 32'(bus.ocupado), 32'h0);
    verifica("f1_uns", 32'($countones(bus.palavra)), 32'd5);
    verifica("f1_zeros", 32'(16 - $countones(bus.palavra)), 32'd11);
`ifdef DESSER_PARIDADE_EN
    verifica("f1_erro", 32'(bus.erro_paridade), 32'h0);
`endif
    @(negedge clk);
    verifica("f1_valida_fim", 32'(bus.palavra_valida), 32'h0);
    verifica("f1_hold", 32'(bus.palavra), 32'h4A44);
    verifica("f1_pulsos", 32'(n_pulsos), 32'(p0 + 1));

    // Same frame with idle gaps between bits
    p0 = n_pulsos;
    iniciar();
    bits(quadro(16'h4A44), NB, 1'b1);
    verifica("gap_sem_pulso", 32'(n_pulsos), 32'(p0));
    @(negedge clk);
    bus.bit_valido = 1'b0;
    verifica("gap_ocupado", 32'(falhas_gap), 32'h0);
    verifica("gap_valida", 32'(bus.palavra_valida), 32'h1);
    verifica("gap_palavra", 32'(bus.palavra), 32'h4A44);
    verifica("gap_pulsos", 32'(n_pulsos), 32'(p0 + 1));

    // Restart after 7 bits, then frame 0x0001
    p0 = n_pulsos;
    iniciar();
    bits(quadro(16'hABCD), 7, 1'b0);
    iniciar();
    verifica("abort_hold", 32'(bus.palavra), 32'h4A44);
    bits(quadro(16'h0001), NB, 1'b0);
    @(negedge clk);
    bus.bit_valido = 1'b0;
    verifica("abort_palavra", 32'(bus.palavra), 32'h0001);
    verifica("abort_pulsos", 32'(n_pulsos), 32'(p0 + 1));

    // Reset after 10 bits, then frame 0xFFFF
    repeat (2) @(negedge clk);
    p0 = n_pulsos;
    iniciar();
    bits(quadro(16'hFFFF), 10, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus.bit_valido = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    verifica("rstm_palavra", 32'(bus.palavra), 32'h0);
    verifica("rstm_valida", 32'(bus.palavra_valida), 32'h0);
    verifica("rstm_ocupado", 32'(bus.ocupado), 32'h0);
`ifdef DESSER_PARIDADE_EN
    verifica("rstm_erro", 32'(bus.erro_paridade), 32'h0);
`endif
    @(negedge clk);
    verifica("rstm_pulsos", 32'(n_pulsos), 32'(p0));
    iniciar();
    bits(quadro(16'hFFFF), NB, 1'b0);
    @(negedge clk);
    bus.bit_valido = 1'b0;
    verifica("ffff_palavra", 32'(bus.palavra), 32'hFFFF);
    verifica("ffff_pulsos", 32'(n_pulsos), 32'(p0 + 1));

    // Back-to-back: restart during delivery, then frame 0x0000
    repeat (2) @(negedge clk);
    p0 = n_pulsos;
    iniciar();
    bits(quadro(16'h1234), NB, 1'b0);
    @(negedge clk);
    bus.bit_valido = 1'b0;
    bus.inicio     = 1'b1;
    verifica("b2b_valida1", 32'(bus.palavra_valida), 32'h1);
    verifica("b2b_palavra1", 32'(bus.palavra), 32'h1234);
    @(negedge clk);
    bus.inicio = 1'b0;
    verifica("b2b_ocupado", 32'(bus.ocupado), 32'h1);
    verifica("b2b_valida_fim", 32'(bus.palavra_valida), 32'h0);
    bits(quadro(16'h0000), NB, 1'b0);
    @(negedge clk);
    bus.bit_valido = 1'b0;
    verifica("b2b_valida2", 32'(bus.palavra_valida), 32'h1);
    verifica("b2b_palavra2", 32'(bus.palavra), 32'h0000);
    verifica("b2b_pulsos", 32'(n_pulsos), 32'(p0 + 2));

`ifdef DESSER_PARIDADE_EN
    // Even parity: correct bit, then wrong bit
    repeat (2) @(negedge clk);
    iniciar();
    bits({16'h4A44, 1'b1}, NB, 1'b0);
    @(negedge clk);
    bus.bit_valido = 1'b0;
    verifica("par_ok_erro", 32'(bus.erro_paridade), 32'h0);
    verifica("par_ok_palavra", 32'(bus.palavra), 32'h4A44);
    iniciar();
    bits({16'h4A44, 1'b0}, NB, 1'b0);
    @(negedge clk);
    bus.bit_valido = 1'b0;
    verifica("par_bad_erro", 32'(bus.erro_paridade), 32'h1);
    verifica("par_bad_palavra", 32'(bus.palavra), 32'h4A44);
    verifica("par_bad_valida", 32'(bus.palavra_valida), 32'h1);
    repeat (2) @(negedge clk);
    verifica("par_bad_hold", 32'(bus.erro_paridade), 32'h1);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_erros);
    $finish;
  end

endmodule

// File: doc/desserializador_palavra.md
DESSERIALIZADOR_PALAVRA -- requirements
Module: desserializador_palavra

Interface
REQ-001 SHALL have parameter: LARGURA, 16, word width in bits (delivered word feeds the 16-bit popcount stage).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: inicio  input  1  frame start; arms or restarts reception.
REQ-005 SHALL have port: bit_in  input  1  serial data bit, MSB first.
REQ-006 SHALL have port: bit_valido  input  1  bit_in is sampled only on cycles where this is 1.
REQ-007 SHALL have port: palavra  output  LARGURA  last assembled word; drives entrada of the popcount stage.
REQ-008 SHALL have port: palavra_valida  output  1  one-cycle pulse marking a new palavra.
REQ-009 SHALL have port: ocupado  output  1  frame reception in progress.
REQ-010 SHALL have port: erro_paridade  output  1  parity result of last frame (present only with DESSER_PARIDADE_EN).

Function
REQ-011 SHALL implement FSM states OCIOSO, RECEBE, PARIDADE (macro only), ENTREGA.
REQ-012 OCIOSO: inicio=1 -> RECEBE, shift register and bit counter cleared; bit_in on that cycle SHALL NOT be captured.
REQ-013 RECEBE: each cycle with bit_valido=1 SHALL shift bit_in into LSB (first bit ends at bit LARGURA-1) and increment counter; bit_valido=0 holds all state.
REQ-014 RECEBE: on acceptance of bit number LARGURA -> ENTREGA (or PARIDADE with macro); counter width SHALL be $clog2(LARGURA+1), no wrap past LARGURA.
REQ-015 ENTREGA: palavra SHALL be loaded on the edge leaving the last-bit state and palavra_valida=1 for exactly that one following cycle; latency = 1 cycle after the edge sampling the final bit.
REQ-016 ENTREGA -> OCIOSO, or -> RECEBE if inicio=1 in ENTREGA (back-to-back frames, pulse still emitted).
REQ-017 inicio=1 in RECEBE or PARIDADE SHALL discard the partial frame, clear counter, stay/return to RECEBE; a simultaneous bit_valido bit is dropped.
REQ-018 palavra SHALL hold its value between deliveries; partial frames never alter it.
REQ-019 ocupado SHALL be 1 exactly in RECEBE and PARIDADE.

Reset
REQ-020 rst=1 at a clock edge SHALL force OCIOSO, counter=0, shift register=0, palavra=0, palavra_valida=0, ocupado=0, erro_paridade=0; rst overrides inicio and bit_valido.
REQ-021 rst mid-frame SHALL abandon the frame with no palavra_valida pulse.

Configuration
REQ-022 Macro DESSER_PARIDADE_EN SHALL enable even-parity checking.
REQ-023 With macro: after LARGURA data bits, PARIDADE waits for one more valid bit; erro_paridade = (^data) ^ parity bit, updated with palavra at ENTREGA and held until next delivery; word delivered regardless of error.
REQ-024 Without macro: no PARIDADE state, no erro_paridade port, RECEBE goes directly to ENTREGA.

Structure
REQ-025 Package desserializador_pkg SHALL hold the state enum type and LARGURA_PADRAO=16.
REQ-026 Sub-module contador_bits SHALL provide the bit counter (clear, enable, terminal-count flag).

Verification
REQ-027 Reset, then 16 valid bits of 16'b0100101001000100 MSB first -> palavra=16'h4A44, one-cycle palavra_valida, downstream popcount 5 ones / 11 zeros.
REQ-028 Frame of 16 valid bits with bit_valido=0 gaps between them -> same palavra as gap-free frame; ocupado=1 throughout, pulse only after bit 16.
REQ-029 inicio reasserted after 7 bits, then full frame 16'h0001 -> palavra=16'h0001, no pulse for the aborted frame.
REQ-030 rst raised after 10 bits -> all outputs 0, no pulse; next full frame 16'hFFFF -> palavra=16'hFFFF.
REQ-031 inicio=1 during ENTREGA, then frame 16'h0000 -> two consecutive deliveries, second palavra=16'h0000.
REQ-032 With DESSER_PARIDADE_EN: 16'h4A44 plus parity bit 1 -> erro_paridade=0; parity bit 0 -> erro_paridade=1, palavra=16'h4A44 both times.
